dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory (`dmem`: combinational read, write on rising `clk`) between the MIPS core (port 0) and a host/DMA requester (port 1). Each cycle it grants at most one requester, drives the memory address/write strobes from the winner, and returns registered read data with a one-cycle `rvalid`. It sits between `mips` and `dmem` inside `top`; the core stalls on `p0_gnt` low.

## Interface
- `DW`, 32, data width
- `AW`, 32, address width (byte address; memory ignores bits [1:0])
- `LOCK_MAX`, 8, maximum consecutive locked grants to port 1 (1..255)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `p0_req`  in  1  core request
- `p0_we`  in  1  core write (1) / read (0)
- `p0_addr`  in  AW  core byte address
- `p0_wdata`  in  DW  core write data
- `p0_gnt`  out  1  core granted this cycle (combinational)
- `p0_rdata`  out  DW  registered read data for port 0
- `p0_rvalid`  out  1  `p0_rdata` valid (one cycle after a granted read)
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_gnt`, `p1_rdata`, `p1_rvalid`: same as port 0, for host
- `p1_lock`  in  1  host requests to retain ownership next cycle (burst)
- `mem_we`  out  1  to `dmem.we`
- `mem_addr`  out  AW  to `dmem.a`
- `mem_wdata`  out  DW  to `dmem.wd`
- `mem_rdata`  in  DW  from `dmem.rd`

## Operation
- Grant computed combinationally from requests and registered state; a granted transaction completes in its grant cycle (write committed at that rising edge; read data sampled into `pN_rdata` at that edge).
- States: `ARB` (normal arbitration), `LOCK1` (port 1 owns memory).
- `ARB`: only one requester → it wins. Both → winner per priority policy (see Configuration). Neither → no grant.
- `ARB` → `LOCK1` when port 1 granted with `p1_lock=1` and `LOCK_MAX>1`; lock counter loaded with 1.
- `LOCK1`: `p1_gnt = p1_req`; `p0_gnt = 0` even if `p1_req=0` (ownership held). Each edge with `p1_lock=1` increments counter; stay while `p1_lock=1` and counter < `LOCK_MAX`.
- `LOCK1` → `ARB` when `p1_lock=0` or counter reaches `LOCK_MAX`; on forced exit (counter limit) port 0 has absolute priority in the next `ARB` cycle if `p0_req=1`.
- Round-robin pointer `last` records last granted port; updated only on a grant.
- Mux: `mem_addr/mem_wdata/mem_we` from winner; no grant → `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- `pN_rvalid` set one cycle after a granted read by port N; cleared otherwise. `pN_rdata` holds last read value until the next granted read by that port.
- Writes produce no `rvalid`.

## Timing
- Reset (`reset=0`, async): state `ARB`, `last=1` (port 0 wins first tie), lock counter 0, `p0_rvalid=p1_rvalid=0`, `p0_rdata=p1_rdata=0`. Grants/`mem_*` are combinational, but forced to 0 while `reset=0`.
- Grant latency 0 cycles; read latency 1 cycle (grant at edge k, `rvalid`/`rdata` valid during cycle k+1).
- Requester must hold `req/we/addr/wdata` stable until the cycle it sees `gnt=1`; deasserting `req` before grant is legal (request dropped, no side effects).
- Back-to-back grants to the same port every cycle allowed; `rvalid` may stay high consecutive cycles.
- Reset asserted mid-lock: returns to `ARB` immediately, pending `rvalid` cleared; a write at the same edge as reset assertion is not guaranteed.
- `LOCK_MAX=1`: `LOCK1` never entered; `p1_lock` ignored.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin tie-break — on simultaneous `p0_req`,`p1_req` in `ARB`, the port not equal to `last` wins.
- Not defined: fixed priority — port 0 always wins ties; `last` still maintained but unused. Lock and forced-release behaviour unchanged.

## Test plan
- Reset: hold `reset=0` with both reqs high → all gnt 0, `mem_we=0`, rvalids 0; release → first cycle p0 wins.
- Single writer/reader: p0 write addr 0x54 data 0xC, next cycle p0 read 0x54 → `p0_rvalid=1`, `p0_rdata=0xC` one cycle after read grant.
- Contention, `DMEM_ARB_RR_EN` defined: both request reads 4 cycles → grants alternate p0,p1,p0,p1; undefined → p0 all 4, p1 0.
- Lock: p1 burst with `p1_lock=1`, `p0_req=1` throughout, `LOCK_MAX=8` → p1 granted 8 consecutive cycles, then p0 granted next cycle.
- Lock early release: p1 lock 3 cycles then `p1_lock=0` → p0 granted cycle 4; lock with `p1_req=0` for one cycle → neither granted that cycle.
- Async reset mid-lock (cycle 4 of burst) → state `ARB`, rvalids drop immediately, after release p0 wins tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-port data memory between the MIPS core (port 0) and a host/DMA port (port 1).
// Optional feature macro: DMEM_ARB_RR_EN (round-robin tie-break; fixed priority to port 0 when undefined).
module dmem_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic          p1_lock,
  output logic          p1_gnt,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {ARB, LOCK1} state_t;

  localparam bit         LOCK_EN = (LOCK_MAX > 1);
  localparam logic [8:0] LOCK_LIM = 9'(LOCK_MAX);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_lock_cnt, w_lock_cnt_nxt;
  logic [8:0] w_lock_cnt_inc;
  logic       r_force_p0, w_force_p0_nxt;
  logic       r_last;
  logic       w_g0, w_g1;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (reset) begin
      if (r_state == LOCK1) begin
        w_g1 = p1_req;
      end else if (p0_req && p1_req) begin
        if (r_force_p0) begin
          w_g0 = 1'b1;
        end else begin
`ifdef DMEM_ARB_RR_EN
          w_g0 = r_last;
          w_g1 = ~r_last;
`else
          w_g0 = 1'b1;
`endif
        end
      end else begin
        w_g0 = p0_req;
        w_g1 = p1_req;
      end
    end
  end

`ifndef DMEM_ARB_RR_EN
  // The pointer is still tracked so switching policy needs no other change.
  logic w_unused_last;
  assign w_unused_last = r_last;
`endif

  assign w_lock_cnt_inc = {1'b0, r_lock_cnt} + 9'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_force_p0_nxt = 1'b0;
    case (r_state)
      ARB: begin
        if (LOCK_EN && w_g1 && p1_lock) begin
          w_state_nxt    = LOCK1;
          w_lock_cnt_nxt = 8'd1;
        end
      end
      LOCK1: begin
        if (!p1_lock) begin
          w_state_nxt    = ARB;
          w_lock_cnt_nxt = 8'd0;
        end else if (w_lock_cnt_inc >= LOCK_LIM) begin
          // Limit reached: hand the next tie to the core so it cannot starve.
          w_state_nxt    = ARB;
          w_lock_cnt_nxt = 8'd0;
          w_force_p0_nxt = 1'b1;
        end else begin
          w_lock_cnt_nxt = w_lock_cnt_inc[7:0];
        end
      end
      default: begin
        w_state_nxt    = ARB;
        w_lock_cnt_nxt = 8'd0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ARB;
      r_lock_cnt <= 8'd0;
      r_force_p0 <= 1'b0;
      r_last     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_force_p0 <= w_force_p0_nxt;
      if (w_g0)      r_last <= 1'b0;
      else if (w_g1) r_last <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= w_g0 & ~p0_we;
      p1_rvalid <= w_g1 & ~p1_we;
      if (w_g0 && !p0_we) p0_rdata <= mem_rdata;
      if (w_g1 && !p1_we) p1_rdata <= mem_rdata;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_g0) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (w_g1) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  assign p0_gnt = w_g0;
  assign p1_gnt = w_g1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grant sequencing, lock bursts, reset and registered read data via a scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] last_rd0, last_rd1;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DW(32), .AW(32), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: combinational read, write on rising clk.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic lk);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    p1_lock = lk;
  endtask

  // One cycle: check outputs of the previous edge and this cycle's grant, update the model, wait for the next negedge.
  task automatic tick(input logic eg0, input logic eg1);
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    #1;
    chk("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, q0.size() != 0});
    if (q0.size() != 0) last_rd0 = q0.pop_front();
    chk("p0_rdata", p0_rdata, last_rd0);
    chk("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, q1.size() != 0});
    if (q1.size() != 0) last_rd1 = q1.pop_front();
    chk("p1_rdata", p1_rdata, last_rd1);
    chk("p0_gnt", {31'd0, p0_gnt}, {31'd0, eg0});
    chk("p1_gnt", {31'd0, p1_gnt}, {31'd0, eg1});
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (eg0) begin
      e_we = p0_we; e_addr = p0_addr; e_wdata = p0_wdata;
      if (p0_we) ref_mem[p0_addr[7:2]] = p0_wdata;
      else       q0.push_back(ref_mem[p0_addr[7:2]]);
    end else if (eg1) begin
      e_we = p1_we; e_addr = p1_addr; e_wdata = p1_wdata;
      if (p1_we) ref_mem[p1_addr[7:2]] = p1_wdata;
      else       q1.push_back(ref_mem[p1_addr[7:2]]);
    end
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA000_0000 + i;
      ref_mem[i] = 32'hA000_0000 + i;
    end
    last_rd0 = '0;
    last_rd1 = '0;
    reset = 1'b0;
    drive(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0);

    // Reset held with both requesting: nothing granted.
    @(negedge clk);
    tick(0, 0);
    tick(0, 0);

    // Release: port 0 wins the first tie.
    reset = 1'b1;
    tick(1, 0);

    // Single writer then reader.
    drive(1, 1, 32'h54, 32'hC, 0, 0, 0, 0, 0);
    tick(1, 0);
    drive(1, 0, 32'h54, 0, 0, 0, 0, 0, 0);
    tick(1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0);

    // Port 1 solo read leaves last=1 before contention.
    drive(0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
    tick(0, 1);

    // Contention, both reading for four cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h30 + 4 * i, 0, 1, 0, 32'h40 + 4 * i, 0, 0);
`ifdef DMEM_ARB_RR_EN
      tick(i % 2 == 0, i % 2 == 1);
`else
      tick(1, 0);
`endif
    end

    // Full lock burst: eight port 1 grants, then port 0.
    drive(0, 0, 32'h60, 0, 1, 0, 32'h80, 0, 1);
    tick(0, 1);
    for (int i = 1; i < 8; i++) begin
      drive(1, 0, 32'h60, 0, 1, (i == 2), 32'h80 + 4 * i, 32'h5A00 + i, 1);
      tick(0, 1);
    end
    drive(1, 0, 32'h88, 0, 1, 0, 32'h88, 0, 1);
    tick(1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0);

    // Early release: lock dropped in the third owned cycle, port 0 wins the fourth.
    drive(0, 0, 32'h64, 0, 1, 0, 32'h90, 0, 1);
    tick(0, 1);
    drive(1, 0, 32'h64, 0, 1, 0, 32'h94, 0, 1);
    tick(0, 1);
    drive(1, 0, 32'h64, 0, 1, 0, 32'h98, 0, 0);
    tick(0, 1);
    drive(1, 0, 32'h64, 0, 1, 0, 32'h9C, 0, 0);
    tick(1, 0);

    // Lock held with p1_req low: nobody granted that cycle.
    drive(0, 0, 32'h68, 0, 1, 0, 32'hA0, 0, 1);
    tick(0, 1);
    drive(1, 0, 32'h68, 0, 0, 0, 32'hA4, 0, 1);
    tick(0, 0);
    drive(1, 0, 32'h68, 0, 1, 0, 32'hA4, 0, 0);
    tick(0, 1);
    drive(1, 0, 32'h68, 0, 0, 0, 0, 0, 0);
    tick(1, 0);

    // Async reset in the fourth cycle of a burst.
    drive(0, 0, 32'h6C, 0, 1, 0, 32'hB0, 0, 1);
    tick(0, 1);
    drive(1, 0, 32'h6C, 0, 1, 0, 32'hB4, 0, 1);
    tick(0, 1);
    drive(1, 0, 32'h6C, 0, 1, 0, 32'hB8, 0, 1);
    tick(0, 1);
    drive(1, 0, 32'h6C, 0, 1, 0, 32'hBC, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    chk("rst_p1_rdata", p1_rdata, 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_p1_gnt", {31'd0, p1_gnt}, 32'd0);
    chk("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    q0.delete();
    q1.delete();
    last_rd0 = '0;
    last_rd1 = '0;
    @(negedge clk);
    drive(1, 0, 32'h70, 0, 1, 0, 32'hC0, 0, 1);
    reset = 1'b1;
    tick(1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
